// File: rtl/error_counter_pkg.sv
// Shared types and helpers for the multi-channel error counter bank.
package error_counter_pkg;

    localparam int unsigned NUM_CH_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT  = 10;
    localparam int unsigned CNT_W_MAX      = 16;

    // Per-channel state record; count is sized for the widest legal counter.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] count;
        logic                 flag;
    } ch_state_t;

    // Increment, holding at the all-ones value of a width-bit counter.
    function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] value,
                                                     input int unsigned width);
        logic [CNT_W_MAX-1:0] max_value;
        max_value = CNT_W_MAX'((32'd1 << width) - 32'd1);
        if (value >= max_value) begin
            return value;
        end
        return value + CNT_W_MAX'(1);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/error_counter_bank.sv
// Multi-channel error edge counter with sticky flags, masked summary and
// addressed read port; optional triplicated state with per-cycle scrubbing.
module error_counter_bank
    import error_counter_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEFAULT,
    parameter int unsigned CNT_WIDTH   = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TMR         = 1,
    parameter int unsigned AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_CH-1:0]    ErrorIn,
    input  logic [NUM_CH-1:0]    ErrorMask,
    output logic                 ErrorOut,
    output logic [NUM_CH-1:0]    ErrorFlags,
    input  logic                 ReadReq,
    input  logic [AW-1:0]        ReadAddr,
    input  logic                 ClearOnRead,
    output logic                 ReadValid,
    output logic [CNT_WIDTH-1:0] ReadData,
    output logic                 ReadSat,
    output logic                 ReadErr,
    input  logic                 ClearAll,
    input  logic                 ClearCh,
    input  logic [AW-1:0]        ClearAddr
);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] dly_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] flags;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_v;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 rd_ok;

    // Input synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= ErrorIn;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic      clr;
        ch_state_t c0_q;
        ch_state_t voted;
        ch_state_t nxt;

        assign clr = ClearAll
                   | (ClearCh && (ClearAddr == AW'(i)))
                   | (ReadReq && ClearOnRead && (ReadAddr == AW'(i)));

        // Clear first, then apply the edge so a coincident event survives.
        always_comb begin
            if (clr) begin
                nxt = '0;
            end else begin
                nxt = voted;
            end
            if (rise[i]) begin
                nxt.count = sat_inc(nxt.count, CNT_WIDTH);
                nxt.flag  = 1'b1;
            end
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                c0_q <= '0;
            end else begin
                c0_q <= nxt;
            end
        end

        if (TMR != 0) begin : g_tmr
            ch_state_t c1_q;
            ch_state_t c2_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    c1_q <= '0;
                    c2_q <= '0;
                end else begin
                    c1_q <= nxt;
                    c2_q <= nxt;
                end
            end

            tmr_vote #(.WIDTH($bits(ch_state_t))) u_vote (
                .a(c0_q),
                .b(c1_q),
                .c(c2_q),
                .y(voted)
            );
        end else begin : g_single
            assign voted = c0_q;
        end

        assign flags[i] = voted.flag;
        assign cnt_v[i] = voted.count[CNT_WIDTH-1:0];
    end

    assign ErrorFlags = flags;

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ReadAddr == AW'(i)) begin
                rd_cnt = cnt_v[i];
            end
        end
    end

    assign rd_ok = 32'(ReadAddr) < NUM_CH;

    // Registered summary and read response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ErrorOut  <= 1'b0;
            ReadValid <= 1'b0;
            ReadErr   <= 1'b0;
            ReadSat   <= 1'b0;
            ReadData  <= '0;
        end else begin
            ErrorOut  <= |(flags & ~ErrorMask);
            ReadValid <= ReadReq;
            ReadErr   <= ReadReq && !rd_ok;
            if (ReadReq) begin
                ReadData <= rd_ok ? rd_cnt : '0;
                ReadSat  <= rd_ok && (&rd_cnt);
            end
        end
    end

endmodule

// File: doc/error_counter_bank.md
Name: error_counter_bank

Overview:
Parametrised multi-channel error counter, successor to the single-channel triplicated error counter. It synchronises NUM_CH asynchronous error lines and counts the rising edges on each line in its own saturating counter. It keeps a sticky flag per channel and drives a masked summary output. Counters are read through an addressed request/valid port with optional clear-on-read. It sits in the readout-control error block; the global register file reads it.

Parameters:
NUM_CH, 8, number of error channels (1..32)
CNT_WIDTH, 10, counter width per channel (4..16)
SYNC_STAGES, 2, input synchroniser depth (2..3)
TMR, 1, 1 = triplicate counters and sticky flags with majority vote; 0 = single copy
AW, $clog2(NUM_CH) (min 1), read/clear address width (derived)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
ErrorIn  in  NUM_CH  raw per-channel error lines, asynchronous to Clk
ErrorMask  in  NUM_CH  1 = exclude channel from ErrorOut (counting continues)
ErrorOut  out  1  OR over channels of (sticky flag AND NOT mask), registered
ErrorFlags  out  NUM_CH  voted sticky flags, unmasked
ReadReq  in  1  single-cycle read strobe
ReadAddr  in  AW  channel to read
ClearOnRead  in  1  sampled with ReadReq; 1 = clear the addressed counter and flag after the read
ReadValid  out  1  one-cycle pulse, ReadData valid
ReadData  out  CNT_WIDTH  voted counter value; holds last value between reads
ReadSat  out  1  addressed counter was saturated (all ones) at read time
ReadErr  out  1  ReadAddr >= NUM_CH; pulses with ReadValid
ClearAll  in  1  clear all counters and flags
ClearCh  in  1  clear one channel
ClearAddr  in  AW  channel for ClearCh

Behaviour:
- Reset (sync, high): synchronisers, edge registers, counters and flags go to 0. ErrorOut, ReadValid, ReadSat and ReadErr go to 0. ReadData goes to 0. Reset has priority over everything.
- Sync: each ErrorIn passes through SYNC_STAGES flops, then through one delay flop. edge[i] = sync_out[i] AND NOT delayed[i].
- Latency: if ErrorIn[i] is first sampled high at edge t0, the count and flag update at edge t0+SYNC_STAGES. ErrorOut updates one edge later.
- A held-high input counts once. Re-counting needs a low level for at least one synchronised sample.
- Counter: on edge[i], if count < 2^CNT_WIDTH-1 then count+1; otherwise hold (saturate, no wrap). On edge[i], flag[i] is set to 1.
- Clear priority (per channel): Reset > ClearAll > (ClearCh with ClearAddr==i) > clear-on-read > increment.
- If a clear and an edge happen in the same cycle, the result is count=1 and flag=1. The new event is not lost.
- ClearCh or clear-on-read with an address >= NUM_CH is ignored.
- Read: when ReadReq=1 at edge t, the following are registered at edge t+1:
  - ReadValid=1
  - ReadData = count[ReadAddr] as of before edge t
  - ReadSat set if that value is all ones
- Clear-on-read: the addressed counter and flag are cleared at edge t, so an event at edge t leaves count=1.
- Out-of-range read: ReadData=0, ReadSat=0, ReadErr=1, no clear.
- Back-to-back ReadReq is allowed, one result per cycle.
- TMR=1: every counter and flag has three copies. Each copy loads next-state from the voted value every cycle, so a single upset is scrubbed in one cycle. All outputs use voted values.
- TMR=0: single copy, identical function.
- ErrorMask affects only ErrorOut. ErrorOut is registered with zero extra latency relative to the flags, i.e. one edge after the flag update.

Decomposition:
- Package error_counter_pkg:
  - constants CNT_W_DEFAULT, NUM_CH_DEFAULT
  - function for saturating increment
  - typedef for the per-channel state record {count, flag}
- Sub-module tmr_vote (parameter WIDTH): bitwise 2-of-3 majority. It is instantiated per channel when TMR=1 and bypassed by a generate when TMR=0.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset, then a 3-cycle pulse on ErrorIn[2] -> after SYNC_STAGES edges count[2]=1 and ErrorFlags=0x04; ErrorOut=1 one edge later; other counters stay 0.
- 1030 separated pulses on ErrorIn[0], CNT_WIDTH=10 -> read ch0 gives ReadData=0x3FF, ReadSat=1; further pulses do not wrap.
- ErrorMask[5]=1 with pulses on ch5 -> count[5] increments, ErrorFlags[5]=1, ErrorOut stays 0; clearing the mask gives ErrorOut=1 next edge.
- Read ch3 (count=7) with ClearOnRead=1, plus an edge on ch3 in the same cycle -> ReadData=7 and ReadValid pulse; a later read gives 1.
- ClearAll asserted in the same cycle as an edge on ch1 -> count[1]=1, all other counts 0. ReadAddr=NUM_CH gives ReadErr=1, ReadData=0.
- TMR=1: force one copy of count[4] to 0x155 while the true value is 0x0AA -> voted read 0x0AA; the next cycle all copies equal 0x0AA.
